spi_target_regbank: RTL and testbench
=====================================

# spi_target_regbank

Serial responder for the single-wire-per-direction SPI frame protocol used by `spi_controller`. It decodes command frames arriving on `mosi` while `cs_n` is low and commits writes into an internal register bank. On reads it returns data serially on `miso`, using the `ready`/`op_done` handshake back to the initiator. It is the responder end of the link, a drop-in alternative to the existing memory target, and adds a read-only ID register, out-of-range handling and frame-abort recovery.

## Interface
- `DEPTH`, 32: number of 8-bit registers (1..255); valid addresses 0..DEPTH-1
- `ID_ADDR`, 8'hFF: read-only identification address (must be >= DEPTH)
- `ID_VALUE`, 8'hA5: value returned for reads of `ID_ADDR`
- `clk`  in  1  system clock; all serial bits move one per rising edge
- `rst_n`  in  1  reset, synchronous, active-low
- `cs_n`  in  1  frame select from initiator, active-low
- `mosi`  in  1  serial data from initiator, LSB first
- `miso`  out  1  serial read data to initiator, LSB first
- `ready`  out  1  one-cycle pulse: read data follows on `miso` starting next cycle
- `op_done`  out  1  one-cycle pulse: frame completed (write committed or read shifted out)
- `range_err`  out  1  sticky flag; set by any out-of-range access, cleared by reset only

## Operation
- Frame format, bits sampled on `mosi` at rising `clk` while `cs_n`=0: bit 0 = command (1 write, 0 read), then 8 address bits LSB first, then (write only) 8 data bits LSB first.
- States: IDLE, ADDR, WDATA, COMMIT, RREADY, RDATA, DONE.
- IDLE: on the first edge with `cs_n`=0, capture command bit and go to ADDR.
- ADDR: shift 8 bits. After bit 7, a write goes to WDATA. A read loads the 8-bit read shift register and goes to RREADY.
- WDATA: shift 8 bits, then go to COMMIT.
- COMMIT: if addr < DEPTH, write the register. Otherwise drop the write and set `range_err`. Writes to `ID_ADDR` are dropped but do not set `range_err`. Then go to DONE.
- Read data source: bank[addr] if addr < DEPTH; `ID_VALUE` if addr == `ID_ADDR`; otherwise 8'hFF and set `range_err`.
- RREADY: `ready`=1 for exactly this cycle, then go to RDATA.
- RDATA: drive `miso` = shift[0] for 8 cycles, shifting right each cycle, then go to DONE.
- DONE: `op_done`=1 for exactly this cycle, then go to IDLE. The target does not require `cs_n` to rise between frames.
- Abort: `cs_n`=1 in any state other than IDLE/DONE returns to IDLE on the next edge. No write commits, no `op_done` is issued, and `range_err` keeps its value.
- Bank contents are not reset; only control state, outputs and `range_err` are.

## Timing
- Reset (rst_n=0 at an edge): state IDLE, `miso`=0, `ready`=0, `op_done`=0, `range_err`=0, shift registers 0.
- Edge numbering: E0 is the first edge sampling `cs_n`=0 (command bit).
- Address bits are sampled at E1..E8.
- Write: data bits at E9..E16; bank updated at E17; `op_done` high in the cycle after E17.
- Read: `ready` high in the cycle after E8; `miso` carries bits 0..7 in the cycles after E9..E16; `op_done` high in the cycle after E17.
- `miso` is 0 whenever the state is not RDATA. `ready` and `op_done` are never high together.
- A new frame's command bit can be sampled on the edge that leaves DONE, giving back-to-back frames with no idle cycle.
- `cs_n` rising on the same edge that would complete a shift is an abort; abort takes priority.

## Structure
- Shared package `spi_pkg`:
  - state enum `spi_tgt_state_e`
  - constants `SPI_CMD_WRITE`=1'b1, `SPI_ADDR_BITS`=8, `SPI_DATA_BITS`=8
- Sub-module `spi_bit_shifter`: 8-bit LSB-first shift register with load, shift-in and shift-out, plus a 3-bit bit counter with a last-bit flag.
  - One instance is used for the address.
  - One instance is shared for write data and read data, since the two phases are mutually exclusive.

## Test plan
- Write 8'h3C to addr 5, then read addr 5:
  - write `op_done` at E17+1; no `ready` during the write
  - read `ready` at E8+1; `miso` serial 0,0,1,1,1,1,0,0; `op_done` follows
- Read `ID_ADDR` (8'hFF) returns 8'hA5 with `range_err` still 0. Write 8'h00 to 8'hFF, then read it back: still 8'hA5.
- Write 8'h11 to addr 40 (DEPTH=32): `op_done` pulses and `range_err`=1. A read of addr 40 returns 8'hFF. Addr 8 (alias of 40 mod 32) is unchanged.
- Abort: raise `cs_n` after write data bit 3 to addr 2. Required: no `op_done`, addr 2 unchanged, state returns to IDLE. The next full frame then works.
- Back-to-back: write addr 1 then read addr 1 with `cs_n` held low across both. Read returns the written value and `op_done` pulses once per frame.
- Reset mid-read during RDATA: outputs return to reset values on the next edge. A following read of the same address returns the same data.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI responder: FSM states, frame field widths, address decode.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package spi_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_WDATA,
        ST_COMMIT,
        ST_RREADY,
        ST_RDATA,
        ST_DONE
    } spi_tgt_state_e;

    localparam logic SPI_CMD_WRITE = 1'b1;
    localparam int   SPI_ADDR_BITS = 8;
    localparam int   SPI_DATA_BITS = 8;

    // Where an 8-bit frame address lands: inside the bank, on the ID register, or nowhere.
    typedef struct packed {
        logic in_bank;
        logic is_id;
    } spi_addr_class_t;

    function automatic spi_addr_class_t spi_classify(
        input logic [SPI_ADDR_BITS-1:0] addr,
        input int                       depth,
        input logic [SPI_ADDR_BITS-1:0] id_addr
    );
        spi_addr_class_t c;
        c.in_bank = ({24'd0, addr} < depth);
        c.is_id   = (addr == id_addr);
        return c;
    endfunction

endpackage

// File: rtl/spi_target_regbank_if.sv
// Serial link between an SPI initiator and the register-bank responder.
// Latency: n/a (wires only).
// Backpressure: none; the responder paces reads with ready/op_done.
interface spi_target_regbank_if;

    logic cs_n;
    logic mosi;
    logic miso;
    logic ready;
    logic op_done;
    logic range_err;

    modport master (
        output cs_n,
        output mosi,
        input  miso,
        input  ready,
        input  op_done,
        input  range_err
    );

    modport slave (
        input  cs_n,
        input  mosi,
        output miso,
        output ready,
        output op_done,
        output range_err
    );

endinterface

// File: rtl/spi_bit_shifter.sv
// 8-bit LSB-first shift register with parallel load and a 3-bit bit counter flagging the 8th bit.
// Latency: one bit per enabled clk edge; load takes effect on the next edge.
// Backpressure: none; caller gates shift_en.
module spi_bit_shifter
    import spi_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clr,
    input  logic                     load,
    input  logic [SPI_DATA_BITS-1:0] load_dat,
    input  logic                     shift_en,
    input  logic                     shift_in,
    output logic [SPI_DATA_BITS-1:0] q,
    output logic                     last
);

    logic [2:0] cnt;

    // New bits enter at the MSB so the first received bit ends up in bit 0.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q   <= '0;
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (load) begin
            q   <= load_dat;
            cnt <= '0;
        end else if (shift_en) begin
            q   <= {shift_in, q[SPI_DATA_BITS-1:1]};
            cnt <= cnt + 3'd1;
        end
    end

    assign last = (cnt == 3'd7);

endmodule

// File: rtl/spi_target_regbank.sv
// SPI frame responder: decodes cmd/addr/data on mosi, commits writes to a register bank, serialises reads on miso.
// Latency: write commits 17 edges after the command bit; read data starts 10 cycles after it.
// Backpressure: none; cs_n high mid-frame aborts the frame and returns to idle.
module spi_target_regbank
    import spi_pkg::*;
#(
    parameter int                       DEPTH    = 32,
    parameter logic [SPI_ADDR_BITS-1:0] ID_ADDR  = 8'hFF,
    parameter logic [SPI_DATA_BITS-1:0] ID_VALUE = 8'hA5
) (
    input  logic                 clk,
    input  logic                 rst_n,
    spi_target_regbank_if.slave  bus
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    spi_tgt_state_e state;
    spi_tgt_state_e state_nxt;

    logic                     cmd_wr;
    logic                     cmd_cap;
    logic                     cnt_clr;
    logic                     addr_shift;
    logic                     dat_shift;
    logic                     dat_shift_in;
    logic                     dat_load;
    logic                     commit_en;
    logic                     rd_err;
    logic                     range_err_q;
    logic                     addr_last;
    logic                     dat_last;
    logic [SPI_ADDR_BITS-1:0] addr_q;
    logic [SPI_ADDR_BITS-1:0] addr_full;
    logic [SPI_DATA_BITS-1:0] dat_q;
    logic [SPI_DATA_BITS-1:0] rd_val;
    spi_addr_class_t          rd_cls;
    spi_addr_class_t          wr_cls;

    logic [SPI_DATA_BITS-1:0] bank [DEPTH];

    spi_bit_shifter u_addr_shifter (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (cnt_clr),
        .load     (1'b0),
        .load_dat ('0),
        .shift_en (addr_shift),
        .shift_in (bus.mosi),
        .q        (addr_q),
        .last     (addr_last)
    );

    // Write data and read data never overlap within a frame, so one shifter serves both.
    spi_bit_shifter u_dat_shifter (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (cnt_clr),
        .load     (dat_load),
        .load_dat (rd_val),
        .shift_en (dat_shift),
        .shift_in (dat_shift_in),
        .q        (dat_q),
        .last     (dat_last)
    );

    // The read decode runs on the edge that samples address bit 7, before it lands in addr_q.
    assign addr_full    = {bus.mosi, addr_q[SPI_ADDR_BITS-1:1]};
    assign rd_cls       = spi_classify(addr_full, DEPTH, ID_ADDR);
    assign wr_cls       = spi_classify(addr_q, DEPTH, ID_ADDR);
    assign dat_shift_in = (state == ST_WDATA) ? bus.mosi : 1'b0;

    always_comb begin
        rd_val = 8'hFF;
        if (rd_cls.in_bank) begin
            rd_val = bank[addr_full[AW-1:0]];
        end else if (rd_cls.is_id) begin
            rd_val = ID_VALUE;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        cmd_cap    = 1'b0;
        cnt_clr    = 1'b0;
        addr_shift = 1'b0;
        dat_shift  = 1'b0;
        dat_load   = 1'b0;
        commit_en  = 1'b0;
        rd_err     = 1'b0;
        case (state)
            // DONE behaves like IDLE so a new command bit can arrive with no gap.
            ST_IDLE, ST_DONE: begin
                cnt_clr = 1'b1;
                if (!bus.cs_n) begin
                    cmd_cap   = 1'b1;
                    state_nxt = ST_ADDR;
                end else begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_ADDR: begin
                if (bus.cs_n) begin
                    state_nxt = ST_IDLE;
                end else begin
                    addr_shift = 1'b1;
                    if (addr_last) begin
                        if (cmd_wr) begin
                            state_nxt = ST_WDATA;
                        end else begin
                            dat_load  = 1'b1;
                            rd_err    = !rd_cls.in_bank && !rd_cls.is_id;
                            state_nxt = ST_RREADY;
                        end
                    end
                end
            end
            ST_WDATA: begin
                if (bus.cs_n) begin
                    state_nxt = ST_IDLE;
                end else begin
                    dat_shift = 1'b1;
                    if (dat_last) begin
                        state_nxt = ST_COMMIT;
                    end
                end
            end
            ST_COMMIT: begin
                if (bus.cs_n) begin
                    state_nxt = ST_IDLE;
                end else begin
                    commit_en = 1'b1;
                    state_nxt = ST_DONE;
                end
            end
            ST_RREADY: begin
                state_nxt = bus.cs_n ? ST_IDLE : ST_RDATA;
            end
            ST_RDATA: begin
                if (bus.cs_n) begin
                    state_nxt = ST_IDLE;
                end else begin
                    dat_shift = 1'b1;
                    if (dat_last) begin
                        state_nxt = ST_DONE;
                    end
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cmd_wr <= 1'b0;
        end else if (cmd_cap) begin
            cmd_wr <= (bus.mosi == SPI_CMD_WRITE);
        end
    end

    // Bank contents survive reset; only the write strobe is held off while reset is asserted.
    always_ff @(posedge clk) begin
        if (rst_n && commit_en && wr_cls.in_bank) begin
            bank[addr_q[AW-1:0]] <= dat_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            range_err_q <= 1'b0;
        end else if (rd_err || (commit_en && !wr_cls.in_bank && !wr_cls.is_id)) begin
            range_err_q <= 1'b1;
        end
    end

    assign bus.ready     = (state == ST_RREADY);
    assign bus.op_done   = (state == ST_DONE);
    assign bus.miso      = (state == ST_RDATA) && dat_q[0];
    assign bus.range_err = range_err_q;

endmodule

// File: tb/tb_spi_target_regbank.sv
// Randomised frame-level bench for spi_target_regbank against an address-map model of the register bank.
module tb_spi_target_regbank;

    localparam int         DEPTH    = 32;
    localparam logic [7:0] ID_ADDR  = 8'hFF;
    localparam logic [7:0] ID_VALUE = 8'hA5;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    spi_target_regbank_if bus ();

    spi_target_regbank #(
        .DEPTH    (DEPTH),
        .ID_ADDR  (ID_ADDR),
        .ID_VALUE (ID_VALUE)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0] mem [256];
    bit         model_err = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] exp_read(input logic [7:0] a);
        if (int'(a) < DEPTH) return mem[a];
        if (a == ID_ADDR) return ID_VALUE;
        return 8'hFF;
    endfunction

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            bus.cs_n = 1'b1;
            bus.mosi = 1'($urandom);
        end
    endtask

    // One frame, observed for 18 edges (E0..E17). abort_at >= 0 raises cs_n from that edge on;
    // with rst_abort the same edge also samples rst_n low.
    task automatic frame(input bit wr, input logic [7:0] addr, input logic [7:0] dat,
                         input int abort_at, input bit rst_abort, output logic [7:0] rd);
        bit         bits[$];
        int         rdy_k, rdy_n, done_k, done_n, stray, both, exp_rdy;
        bit         aborted, rd_loaded;
        logic [7:0] got, exp_rd;
        rdy_k = -1; rdy_n = 0; done_k = -1; done_n = 0; stray = 0; both = 0;
        got = 8'h00;
        aborted   = (abort_at >= 0);
        rd_loaded = !wr && (!aborted || abort_at > 8);
        exp_rd    = exp_read(addr);
        bits.push_back(wr);
        for (int i = 0; i < 8; i++) bits.push_back(addr[i]);
        if (wr) for (int i = 0; i < 8; i++) bits.push_back(dat[i]);

        for (int k = 0; k < 18; k++) begin
            @(negedge clk);
            if (aborted && k >= abort_at) begin
                bus.cs_n = 1'b1;
                rst_n    = !(rst_abort && k == abort_at);
            end else begin
                bus.cs_n = 1'b0;
            end
            bus.mosi = (k < bits.size()) ? bits[k] : 1'($urandom);
            @(posedge clk);
            #1;
            if (bus.ready) begin
                if (rdy_k < 0) rdy_k = k;
                rdy_n++;
            end
            if (bus.op_done) begin
                if (done_k < 0) done_k = k;
                done_n++;
            end
            if (bus.ready && bus.op_done) both++;
            if (!wr && k >= 9 && k <= 16 && !(aborted && k >= abort_at)) got[k-9] = bus.miso;
            else if (bus.miso !== 1'b0) stray++;
        end
        rst_n = 1'b1;
        rd = got;

        if (wr && !aborted) begin
            if (int'(addr) < DEPTH) mem[addr] = dat;
            else if (addr != ID_ADDR) model_err = 1'b1;
        end
        if (rd_loaded && int'(addr) >= DEPTH && addr != ID_ADDR) model_err = 1'b1;
        if (rst_abort) model_err = 1'b0;

        exp_rdy = rd_loaded ? 8 : -1;
        check("ready_cycle", 32'(rdy_k), 32'(exp_rdy));
        check("ready_count", 32'(rdy_n), rd_loaded ? 32'd1 : 32'd0);
        check("op_done_cycle", 32'(done_k), aborted ? 32'hFFFF_FFFF : 32'd17);
        check("op_done_count", 32'(done_n), aborted ? 32'd0 : 32'd1);
        check("ready_and_done", 32'(both), 32'd0);
        check("miso_stray", 32'(stray), 32'd0);
        check("range_err", 32'(bus.range_err), 32'(model_err));
        if (!wr && !aborted) check("read_data", {24'd0, got}, {24'd0, exp_rd});
    endtask

    logic [7:0] rd;
    logic [7:0] a;

    initial begin
        bus.cs_n = 1'b1;
        bus.mosi = 1'b0;
        rst_n    = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_miso", 32'(bus.miso), 32'd0);
        check("rst_ready", 32'(bus.ready), 32'd0);
        check("rst_op_done", 32'(bus.op_done), 32'd0);
        check("rst_range_err", 32'(bus.range_err), 32'd0);
        rst_n = 1'b1;
        idle(2);

        for (int i = 0; i < DEPTH; i++) begin
            frame(1'b1, 8'(i), 8'($urandom), -1, 1'b0, rd);
            idle(i % 2);
        end

        frame(1'b1, 8'd5, 8'h3C, -1, 1'b0, rd);
        idle(1);
        frame(1'b0, 8'd5, 8'h00, -1, 1'b0, rd);
        check("rd_addr5", {24'd0, rd}, 32'h3C);
        idle(1);

        frame(1'b0, 8'hFF, 8'h00, -1, 1'b0, rd);
        check("rd_id", {24'd0, rd}, 32'hA5);
        check("id_no_err", 32'(bus.range_err), 32'd0);
        frame(1'b1, 8'hFF, 8'h00, -1, 1'b0, rd);
        frame(1'b0, 8'hFF, 8'h00, -1, 1'b0, rd);
        check("rd_id_after_wr", {24'd0, rd}, 32'hA5);
        check("id_wr_no_err", 32'(bus.range_err), 32'd0);
        idle(2);

        frame(1'b1, 8'd40, 8'h11, -1, 1'b0, rd);
        check("oor_wr_err", 32'(bus.range_err), 32'd1);
        idle(1);
        frame(1'b0, 8'd40, 8'h00, -1, 1'b0, rd);
        check("oor_rd", {24'd0, rd}, 32'hFF);
        frame(1'b0, 8'd8, 8'h00, -1, 1'b0, rd);
        idle(1);

        // data bit 3 is sampled at E12, so cs_n rises for E13
        frame(1'b1, 8'd2, 8'h5A ^ mem[2], 13, 1'b0, rd);
        idle(2);
        frame(1'b0, 8'd2, 8'h00, -1, 1'b0, rd);
        idle(1);

        frame(1'b1, 8'd1, 8'hC3, -1, 1'b0, rd);
        frame(1'b0, 8'd1, 8'h00, -1, 1'b0, rd);
        check("b2b_rd", {24'd0, rd}, 32'hC3);
        idle(1);

        frame(1'b0, 8'd5, 8'h00, 12, 1'b1, rd);
        idle(1);
        frame(1'b0, 8'd5, 8'h00, -1, 1'b0, rd);
        check("rd_after_rst", {24'd0, rd}, 32'h3C);
        idle(1);

        for (int i = 0; i < 150; i++) begin
            int  sel, ab;
            bit  wr, ra;
            sel = int'($urandom_range(0, 9));
            if (sel < 7)       a = 8'($urandom_range(0, DEPTH - 1));
            else if (sel == 7) a = ID_ADDR;
            else               a = 8'($urandom_range(DEPTH, 254));
            wr = 1'($urandom);
            ab = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 17)) : -1;
            ra = (ab >= 0) && ($urandom_range(0, 3) == 0);
            frame(wr, a, 8'($urandom), ab, ra, rd);
            idle(int'($urandom_range(0, 2)));
        end

        idle(2);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
